risc_mem_dump: RTL and testbench

//   Hardware memory-dump engine for RiSC bring-up. On start it walks NUM_REGIONS windows of

---
 rtl/risc_mem_dump.sv | 152 +++++++++++++++
 tb/tb_risc_mem_dump.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_mem_dump.sv
// risc_mem_dump: memory-dump engine for RiSC bring-up.
// It walks NUM_REGIONS windows of REGION_WORDS words, starting REGION_STRIDE apart from BASE.
// Each word is read over a spare memory read port and streamed out on a valid/ready port.
// The stream carries end-of-line, end-of-region and last-word flags.
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   start, abort               begin a dump (ignored while busy) / cancel a running dump
//   busy, done, aborted        run status; done pulses once at the end, aborted qualifies it
//   mem_rd, mem_addr           one-cycle read strobe and address
//   mem_rdata                  read data, valid MEM_LAT cycles after mem_rd
//   out_valid, out_ready       stream handshake
//   out_data, out_eol,         dumped word and its line / region / dump-end flags
//   out_eor, out_last
module risc_mem_dump #(
    parameter int unsigned       ADDR_W         = 16,
    parameter int unsigned       DATA_W         = 16,
    parameter logic [ADDR_W-1:0] BASE           = 16'h0,
    parameter int unsigned       NUM_REGIONS    = 4,
    parameter int unsigned       REGION_STRIDE  = 256,
    parameter int unsigned       REGION_WORDS   = 256,
    parameter int unsigned       WORDS_PER_LINE = 16,
    parameter int unsigned       MEM_LAT        = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_eol,
    output logic              out_eor,
    output logic              out_last
);

    localparam int unsigned RegW  = $clog2(NUM_REGIONS + 1);
    localparam int unsigned WordW = $clog2(REGION_WORDS + 1);
    localparam int unsigned LatW  = $clog2(MEM_LAT + 1);
    localparam int unsigned ExtW  = ADDR_W + 8;

    typedef enum logic [2:0] {StIdle, StRead, StWait, StOut, StFin} state_e;

    state_e            state_q, state_d;
    logic [RegW-1:0]   region_q, region_d;
    logic [WordW-1:0]  word_q, word_d;
    logic [LatW-1:0]   lat_q, lat_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              aborted_q, aborted_d;

    logic              eol, eor, last_word;
    logic [ExtW-1:0]   addr_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            region_q  <= '0;
            word_q    <= '0;
            lat_q     <= '0;
            data_q    <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            region_q  <= region_d;
            word_q    <= word_d;
            lat_q     <= lat_d;
            data_q    <= data_d;
            aborted_q <= aborted_d;
        end
    end

    // Position flags of the word currently addressed by the counters.
    always_comb begin
        eol       = (32'(word_q) % WORDS_PER_LINE) == (WORDS_PER_LINE - 1);
        eor       = word_q == WordW'(REGION_WORDS - 1);
        last_word = eor && (region_q == RegW'(NUM_REGIONS - 1));
        // Extra headroom so the product cannot overflow before the final wrap to ADDR_W.
        addr_full = ExtW'(BASE) + ExtW'(region_q) * ExtW'(REGION_STRIDE) + ExtW'(word_q);
    end

    always_comb begin
        state_d   = state_q;
        region_d  = region_q;
        word_d    = word_q;
        lat_d     = lat_q;
        data_d    = data_q;
        aborted_d = aborted_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    region_d  = '0;
                    word_d    = '0;
                    aborted_d = 1'b0;
                    state_d   = StRead;
                end
            end
            StRead: begin
                lat_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (lat_q == LatW'(MEM_LAT - 1)) begin
                    data_d  = mem_rdata;
                    state_d = StOut;
                end else begin
                    lat_d = lat_q + LatW'(1);
                end
            end
            StOut: begin
                if (out_ready) begin
                    if (last_word) begin
                        state_d = StFin;
                    end else begin
                        if (eor) begin
                            word_d   = '0;
                            region_d = region_q + RegW'(1);
                        end else begin
                            word_d = word_q + WordW'(1);
                        end
                        state_d = StRead;
                    end
                end
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Abort overrides everything; a same-cycle handshake has already advanced the counters.
        if (abort && (state_q == StRead || state_q == StWait || state_q == StOut)) begin
            state_d   = StFin;
            aborted_d = 1'b1;
        end
    end

    always_comb begin
        busy      = (state_q == StRead) || (state_q == StWait) || (state_q == StOut);
        done      = state_q == StFin;
        aborted   = (state_q == StFin) && aborted_q;
        mem_rd    = state_q == StRead;
        mem_addr  = (state_q == StRead) ? ADDR_W'(addr_full) : '0;
        out_valid = state_q == StOut;
        out_data  = data_q;
        out_eol   = (state_q == StOut) && eol;
        out_eor   = (state_q == StOut) && eor;
        out_last  = (state_q == StOut) && last_word;
    end

endmodule

// File: tb/tb_risc_mem_dump.sv
module tb_risc_mem_dump;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, abort, out_ready;
    logic        busy, done, aborted, mem_rd, out_valid, out_eol, out_eor, out_last;
    logic [15:0] mem_addr, mem_rdata, out_data;

    logic        start2, abort2, out_ready2;
    logic        busy2, done2, aborted2, mem_rd2, out_valid2, out_eol2, out_eor2, out_last2;
    logic [15:0] mem_addr2, mem_rdata2, out_data2;

    int checks = 0;
    int errors = 0;

    risc_mem_dump dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .busy(busy), .done(done),
        .aborted(aborted), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_eol(out_eol),
        .out_eor(out_eor), .out_last(out_last)
    );

    risc_mem_dump #(
        .BASE(16'hFFFE), .NUM_REGIONS(1), .REGION_STRIDE(4), .REGION_WORDS(4),
        .WORDS_PER_LINE(2), .MEM_LAT(3)
    ) dut2 (
        .clk(clk), .reset(reset), .start(start2), .abort(abort2), .busy(busy2), .done(done2),
        .aborted(aborted2), .mem_rd(mem_rd2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .out_eol(out_eol2), .out_eor(out_eor2), .out_last(out_last2)
    );

    // Memory models: m[a]=a (latency 1) and m[a]=a^5A5A (latency 3); DEAD outside the valid cycle.
    logic        rd_d;
    logic [15:0] a_d;
    logic [2:0]  rd2_p;
    logic [15:0] a2_p [3];
    always @(posedge clk) begin
        if (reset) begin
            rd_d  <= 1'b0;
            rd2_p <= '0;
        end else begin
            rd_d  <= mem_rd;
            rd2_p <= {rd2_p[1:0], mem_rd2};
        end
        a_d     <= mem_addr;
        a2_p[0] <= mem_addr2;
        a2_p[1] <= a2_p[0];
        a2_p[2] <= a2_p[1];
    end
    assign mem_rdata  = rd_d ? a_d : 16'hDEAD;
    assign mem_rdata2 = rd2_p[2] ? (a2_p[2] ^ 16'h5A5A) : 16'hDEAD;

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, aborted, mem_rd, out_valid, out_eol, out_eor, out_last} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {busy, done, aborted, mem_rd, out_valid, out_eol, out_eor, out_last});
        end
        checks++;
        if (mem_addr !== 16'h0) begin
            errors++; $display("FAIL reset_addr: got %h expected 0000", mem_addr);
        end
        checks++;
        if (out_data !== 16'h0) begin
            errors++; $display("FAIL reset_data: got %h expected 0000", out_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // T1 and T3: full default dump, optionally stalling word 2 for 10 cycles.
    task automatic run_full(input bit stall);
        int  idx = 0;
        int  ndone = 0;
        bit  fin = 0;
        bit  held = 0;
        logic [2:0] fl, ef;
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL busy_after_start: got %b expected 1", busy);
        end
        for (int c = 0; c < 8000 && !fin; c++) begin
            if (stall && out_valid && idx == 2 && !held) begin
                out_ready = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    checks++;
                    if ({out_valid, out_data, out_eol, out_eor, out_last, mem_rd} !==
                        {1'b1, 16'h0002, 3'b000, 1'b0}) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%b d=%h f=%b rd=%b expected 1 0002 000 0",
                                 out_valid, out_data, {out_eol, out_eor, out_last}, mem_rd);
                    end
                end
                out_ready = 1'b1;
                held = 1;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== 16'(idx)) begin
                    errors++; $display("FAIL dump_data: got %h expected %h", out_data, 16'(idx));
                end
                fl = {out_eol, out_eor, out_last};
                ef = {idx % 16 == 15, idx % 256 == 255, idx == 1023};
                checks++;
                if (fl !== ef) begin
                    errors++; $display("FAIL dump_flags word %0d: got %b expected %b", idx, fl, ef);
                end
                idx++;
            end
            if (done) begin
                ndone++;
                fin = 1;
                checks++;
                if (aborted !== 1'b0) begin
                    errors++; $display("FAIL dump_aborted: got %b expected 0", aborted);
                end
            end
            if (!fin) @(negedge clk);
        end
        checks++;
        if (!fin) begin
            errors++; $display("FAIL dump_timeout: got no done expected done");
        end
        checks++;
        if (idx != 1024) begin
            errors++; $display("FAIL dump_count: got %0d expected 1024", idx);
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL dump_end: got busy,done=%b expected 00", {busy, done});
        end
    endtask

    task automatic test_full_dump();
        run_full(1'b0);
    endtask

    task automatic test_backpressure();
        run_full(1'b1);
    endtask

    // T5: abort on word 5 under back-pressure; a start pulse while busy is ignored.
    task automatic test_abort();
        int idx = 0;
        bit hit = 0;
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            if (out_valid && idx == 5) begin
                hit = 1;
                checks++;
                if (out_data !== 16'h0005) begin
                    errors++; $display("FAIL abort_word: got %h expected 0005", out_data);
                end
                out_ready = 1'b0;
                abort = 1'b1;
            end else begin
                if (out_valid && out_ready) begin
                    checks++;
                    if (out_data !== 16'(idx)) begin
                        errors++; $display("FAIL abort_seq: got %h expected %h", out_data, 16'(idx));
                    end
                    idx++;
                end
                @(negedge clk);
            end
        end
        checks++;
        if (!hit) begin
            errors++; $display("FAIL abort_timeout: got no word 5 expected word 5");
        end
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({done, aborted, busy, out_valid} !== 4'b1100) begin
            errors++; $display("FAIL abort_fin: got done,aborted,busy,valid=%b expected 1100",
                               {done, aborted, busy, out_valid});
        end
        checks++;
        if (idx != 5) begin
            errors++; $display("FAIL abort_delivered: got %0d expected 5", idx);
        end
        @(negedge clk);
        out_ready = 1'b1;
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++; $display("FAIL abort_idle: got done,busy=%b expected 00", {done, busy});
        end
    endtask

    // T6: asynchronous reset in WAIT, then a fresh dump starts from BASE.
    task automatic test_reset_mid_wait();
        int nrd = 0;
        bit hit = 0;
        bit got = 0;
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            if (mem_rd) nrd++;
            if (nrd == 3) hit = 1;
            else @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if ({busy, mem_rd, out_valid} !== 3'b100 || !hit) begin
            errors++; $display("FAIL wait_state: got busy,rd,valid=%b expected 100",
                               {busy, mem_rd, out_valid});
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, aborted, mem_rd, out_valid, out_eol, out_eor, out_last, mem_addr,
             out_data} !== 40'h0) begin
            errors++; $display("FAIL async_reset: got busy=%b done=%b rd=%b v=%b d=%h",
                               busy, done, mem_rd, out_valid, out_data);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++; $display("FAIL reset_no_done: got %b expected 0", done);
            end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({mem_rd, mem_addr} !== {1'b1, 16'h0000}) begin
            errors++; $display("FAIL restart_addr: got rd=%b a=%h expected 1 0000", mem_rd, mem_addr);
        end
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (out_valid) got = 1;
        end
        checks++;
        if (!got || out_data !== 16'h0000) begin
            errors++; $display("FAIL restart_data: got %h expected 0000", out_data);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({done, aborted} !== 2'b11) begin
            errors++; $display("FAIL restart_abort: got %b expected 11", {done, aborted});
        end
        @(negedge clk);
    endtask

    // T2 and T4: MEM_LAT=3, 4 words from BASE=FFFE wrapping through 0000.
    task automatic test_wrap_latency();
        logic [15:0] ea [4];
        int nrd = 0;
        int idx = 0;
        int last_c = 0;
        bit fin = 0;
        logic [2:0] fl, ef;
        ea[0] = 16'hFFFE; ea[1] = 16'hFFFF; ea[2] = 16'h0000; ea[3] = 16'h0001;
        out_ready2 = 1'b1;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int c = 0; c < 100 && !fin; c++) begin
            if (mem_rd2) begin
                checks++;
                if (nrd > 3 || mem_addr2 !== ea[nrd[1:0]]) begin
                    errors++; $display("FAIL wrap_addr %0d: got %h expected %h",
                                       nrd, mem_addr2, ea[nrd[1:0]]);
                end
                if (nrd > 0) begin
                    checks++;
                    if (c - last_c != 5) begin
                        errors++; $display("FAIL rd_spacing: got %0d expected 5", c - last_c);
                    end
                end
                last_c = c;
                nrd++;
            end
            if (out_valid2 && out_ready2) begin
                checks++;
                if (idx > 3 || out_data2 !== (ea[idx[1:0]] ^ 16'h5A5A)) begin
                    errors++; $display("FAIL lat_data %0d: got %h expected %h",
                                       idx, out_data2, ea[idx[1:0]] ^ 16'h5A5A);
                end
                fl = {out_eol2, out_eor2, out_last2};
                ef = {idx % 2 == 1, idx == 3, idx == 3};
                checks++;
                if (fl !== ef) begin
                    errors++; $display("FAIL lat_flags %0d: got %b expected %b", idx, fl, ef);
                end
                idx++;
            end
            if (done2) begin
                fin = 1;
                checks++;
                if (aborted2 !== 1'b0 || busy2 !== 1'b0) begin
                    errors++; $display("FAIL lat_done: got aborted,busy=%b expected 00",
                                       {aborted2, busy2});
                end
            end
            if (!fin) @(negedge clk);
        end
        checks++;
        if (!fin || nrd != 4 || idx != 4) begin
            errors++; $display("FAIL lat_counts: got fin=%0d rd=%0d words=%0d expected 1 4 4",
                               fin, nrd, idx);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        start2 = 1'b0; abort2 = 1'b0; out_ready2 = 1'b1;
        test_reset();
        test_full_dump();
        test_backpressure();
        test_abort();
        test_reset_mid_wait();
        test_wrap_latency();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
